pc_sequencer: RTL and testbench

- Owns the program counter and selects the next fetch address each cycle.
- Candidate sources: sequential PC+4, PC-relative branch, J/JAL region jump, JR/JALR register target, ERET return, and the exception vector.
- Builds the jump target internally as {PC+4[31:28], instr_index, 2'b00}.
- Holds the PC while a multi-cycle unit (MULT/DIV) stalls, and redirects to the vector on exceptions. Sits between the control unit/CP0 and instruction memory.

---
 rtl/pc_sequencer_if.sv | 27 ++
 rtl/pc_sequencer.sv | 86 ++++++++
 tb/tb_pc_sequencer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Control/CP0 <-> PC sequencer bundle: next-PC selection inputs and fetch-side status.
interface pc_sequencer_if;
  logic [2:0]  pc_sel;
  logic        branch_taken;
  logic [15:0] imm16;
  logic [25:0] instr_index;
  logic [31:0] jr_target;
  logic [31:0] epc;
  logic        exc_req;
  logic        stall_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] npc;
  logic        exc_ack;
  logic        addr_err;
  logic        stalled;

  modport master (
    output pc_sel, branch_taken, imm16, instr_index, jr_target, epc, exc_req, stall_req,
    input  pc, pc_plus4, npc, exc_ack, addr_err, stalled
  );

  modport slave (
    input  pc_sel, branch_taken, imm16, instr_index, jr_target, epc, exc_req, stall_req,
    output pc, pc_plus4, npc, exc_ack, addr_err, stalled
  );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner: picks the next fetch address from seq/branch/jump/jr/eret/vector,
// holding during multi-cycle stalls and trapping misaligned register jumps.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
  input  logic clk,
  input  logic rst_n,
  pc_sequencer_if.slave bus
);

  typedef enum logic {RUN, HOLD} state_t;

  localparam logic [2:0] SEL_SEQ    = 3'd0;
  localparam logic [2:0] SEL_BRANCH = 3'd1;
  localparam logic [2:0] SEL_JUMP   = 3'd2;
  localparam logic [2:0] SEL_JR     = 3'd3;
  localparam logic [2:0] SEL_ERET   = 3'd4;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic        exc_ack_q, exc_ack_nxt;
  logic        addr_err_q, addr_err_nxt;

  logic [31:0] pc_plus4, br_target, j_target, sel_pc;
  logic        jr_misaligned, trap;

  assign pc_plus4      = pc_q + 32'd4;
  assign br_target     = pc_plus4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  assign j_target      = {pc_plus4[31:28], bus.instr_index, 2'b00};
  assign jr_misaligned = (bus.pc_sel == SEL_JR) && (bus.jr_target[1:0] != 2'b00);
  assign trap          = bus.exc_req || jr_misaligned;

  // Source mux; unused encodings 5-7 fall through to sequential.
  always_comb begin
    sel_pc = pc_plus4;
    case (bus.pc_sel)
      SEL_BRANCH: if (bus.branch_taken) sel_pc = br_target;
      SEL_JUMP:   sel_pc = j_target;
      SEL_JR:     sel_pc = bus.jr_target;
      SEL_ERET:   sel_pc = bus.epc;
      default:    sel_pc = pc_plus4;
    endcase
  end

  // Traps outrank the stall in both states, so an exception always aborts a HOLD.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc_q;
    exc_ack_nxt  = 1'b0;
    addr_err_nxt = 1'b0;
    if (trap) begin
      state_nxt    = RUN;
      pc_nxt       = EXC_VECTOR;
      exc_ack_nxt  = 1'b1;
      addr_err_nxt = !bus.exc_req;
    end else if (bus.stall_req) begin
      state_nxt = HOLD;
    end else begin
      state_nxt = RUN;
      pc_nxt    = sel_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      pc_q       <= RESET_PC;
      exc_ack_q  <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc_q       <= pc_nxt;
      exc_ack_q  <= exc_ack_nxt;
      addr_err_q <= addr_err_nxt;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.npc      = trap ? EXC_VECTOR : sel_pc;
  assign bus.exc_ack  = exc_ack_q;
  assign bus.addr_err = addr_err_q;
  assign bus.stalled  = (state == HOLD);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, each PC source, traps, stall/hold and priority.
module tb_pc_sequencer;
  localparam logic [31:0] RESET_PC   = 32'h0040_0000;
  localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  pc_sequencer_if bus ();

  pc_sequencer #(.RESET_PC(RESET_PC), .EXC_VECTOR(EXC_VECTOR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.pc_sel = 3'd0; bus.branch_taken = 1'b0; bus.imm16 = '0; bus.instr_index = '0;
    bus.jr_target = '0; bus.epc = '0; bus.exc_req = 1'b0; bus.stall_req = 1'b0;
  endtask

  // Aligned JR is the quickest way to place the PC anywhere.
  task automatic goto(input logic [31:0] addr);
    bus.pc_sel = 3'd3; bus.jr_target = addr;
    tick();
    bus.pc_sel = 3'd0;
  endtask

  task automatic test_reset();
    logic [31:0] exp_pc;
    rst_n = 1'b0;
    idle_inputs();
    tick(); tick();
    checks++;
    if (bus.pc !== RESET_PC || bus.exc_ack !== 1'b0 || bus.addr_err !== 1'b0 || bus.stalled !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h ack=%b aerr=%b stl=%b, want pc=%h flags 0",
               bus.pc, bus.exc_ack, bus.addr_err, bus.stalled, RESET_PC);
    end
    checks++;
    if (bus.pc_plus4 !== 32'h0040_0004 || bus.npc !== 32'h0040_0004) begin
      errors++;
      $display("FAIL reset_plus4: pc_plus4=%h npc=%h, want 00400004", bus.pc_plus4, bus.npc);
    end
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_pc = exp_pc + 32'd4;
      checks++;
      if (bus.pc !== exp_pc || bus.exc_ack !== 1'b0 || bus.addr_err !== 1'b0 || bus.stalled !== 1'b0) begin
        errors++;
        $display("FAIL seq_%0d: pc=%h ack=%b aerr=%b stl=%b, want pc=%h flags 0",
                 i, bus.pc, bus.exc_ack, bus.addr_err, bus.stalled, exp_pc);
      end
    end
  endtask

  task automatic test_branch();
    goto(32'h0040_0010);
    bus.pc_sel = 3'd1; bus.imm16 = 16'hFFFC; bus.branch_taken = 1'b1;
    #1;
    checks++;
    if (bus.npc !== 32'h0040_0004) begin
      errors++;
      $display("FAIL branch_npc: npc=%h, want 00400004", bus.npc);
    end
    tick();
    checks++;
    if (bus.pc !== 32'h0040_0004) begin
      errors++;
      $display("FAIL branch_taken: pc=%h, want 00400004", bus.pc);
    end
    goto(32'h0040_0010);
    bus.pc_sel = 3'd1; bus.branch_taken = 1'b0;
    tick();
    checks++;
    if (bus.pc !== 32'h0040_0014) begin
      errors++;
      $display("FAIL branch_not_taken: pc=%h, want 00400014", bus.pc);
    end
    idle_inputs();
  endtask

  task automatic test_jump();
    goto(32'h3FFF_FFFC);
    bus.pc_sel = 3'd2; bus.instr_index = 26'h000_0010;
    tick();
    checks++;
    if (bus.pc !== 32'h4000_0040) begin
      errors++;
      $display("FAIL jump_region: pc=%h, want 40000040", bus.pc);
    end
    idle_inputs();
  endtask

  task automatic test_wrap();
    goto(32'hFFFF_FFFC);
    bus.pc_sel = 3'd6;
    #1;
    checks++;
    if (bus.pc_plus4 !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_plus4: pc_plus4=%h, want 00000000", bus.pc_plus4);
    end
    tick();
    checks++;
    if (bus.pc !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_sel6_seq: pc=%h, want 00000000", bus.pc);
    end
    idle_inputs();
  endtask

  task automatic test_jr();
    bus.pc_sel = 3'd3; bus.jr_target = 32'h0040_1002;
    tick();
    checks++;
    if (bus.pc !== EXC_VECTOR || bus.addr_err !== 1'b1 || bus.exc_ack !== 1'b1) begin
      errors++;
      $display("FAIL jr_misaligned: pc=%h aerr=%b ack=%b, want pc=%h aerr=1 ack=1",
               bus.pc, bus.addr_err, bus.exc_ack, EXC_VECTOR);
    end
    bus.jr_target = 32'h0040_1000;
    tick();
    checks++;
    if (bus.pc !== 32'h0040_1000 || bus.addr_err !== 1'b0 || bus.exc_ack !== 1'b0) begin
      errors++;
      $display("FAIL jr_aligned: pc=%h aerr=%b ack=%b, want pc=00401000 aerr=0 ack=0",
               bus.pc, bus.addr_err, bus.exc_ack);
    end
    idle_inputs();
  endtask

  task automatic test_stall();
    goto(32'h0040_0100);
    bus.pc_sel = 3'd2; bus.instr_index = 26'h010_0080; bus.stall_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.pc !== 32'h0040_0100 || bus.stalled !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold_%0d: pc=%h stl=%b, want pc=00400100 stl=1", i, bus.pc, bus.stalled);
      end
    end
    bus.stall_req = 1'b0;
    tick();
    checks++;
    if (bus.pc !== 32'h0040_0200 || bus.stalled !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: pc=%h stl=%b, want pc=00400200 stl=0", bus.pc, bus.stalled);
    end
    bus.pc_sel = 3'd0;
    tick();
    checks++;
    if (bus.pc !== 32'h0040_0204) begin
      errors++;
      $display("FAIL stall_once: pc=%h, want 00400204", bus.pc);
    end

    goto(32'h0040_0100);
    bus.pc_sel = 3'd2; bus.stall_req = 1'b1;
    tick();
    bus.exc_req = 1'b1;
    tick();
    checks++;
    if (bus.pc !== EXC_VECTOR || bus.stalled !== 1'b0 || bus.exc_ack !== 1'b1 || bus.addr_err !== 1'b0) begin
      errors++;
      $display("FAIL stall_exc: pc=%h stl=%b ack=%b aerr=%b, want pc=%h stl=0 ack=1 aerr=0",
               bus.pc, bus.stalled, bus.exc_ack, bus.addr_err, EXC_VECTOR);
    end
    idle_inputs();
    tick();
    checks++;
    if (bus.pc !== 32'h0040_0008 || bus.exc_ack !== 1'b0) begin
      errors++;
      $display("FAIL exc_pulse_end: pc=%h ack=%b, want pc=00400008 ack=0", bus.pc, bus.exc_ack);
    end
  endtask

  task automatic test_priority();
    bus.exc_req = 1'b1; bus.stall_req = 1'b1;
    tick();
    checks++;
    if (bus.pc !== EXC_VECTOR || bus.exc_ack !== 1'b1 || bus.stalled !== 1'b0) begin
      errors++;
      $display("FAIL exc_over_stall: pc=%h ack=%b stl=%b, want pc=%h ack=1 stl=0",
               bus.pc, bus.exc_ack, bus.stalled, EXC_VECTOR);
    end
    idle_inputs();
    bus.pc_sel = 3'd4; bus.epc = 32'h0040_0120;
    tick();
    checks++;
    if (bus.pc !== 32'h0040_0120) begin
      errors++;
      $display("FAIL eret: pc=%h, want 00400120", bus.pc);
    end
    bus.pc_sel = 3'd0; bus.stall_req = 1'b1;
    tick();
    checks++;
    if (bus.stalled !== 1'b1 || bus.pc !== 32'h0040_0120) begin
      errors++;
      $display("FAIL hold_entry: pc=%h stl=%b, want pc=00400120 stl=1", bus.pc, bus.stalled);
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.pc !== RESET_PC || bus.stalled !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_hold: pc=%h stl=%b, want pc=%h stl=0", bus.pc, bus.stalled, RESET_PC);
    end
    rst_n = 1'b1;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_wrap();
    test_jr();
    test_stall();
    test_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
